stage_monitor: RTL and testbench

Synthesizable multi-channel test-stage monitor for the user project area. Each channel watches a firmware-driven stage code and an error flag on GPIO-derived nets, filters glitches, enforces a strict stage sequence and a per-stage watchdog, and reports a single sticky pass/fail verdict. It moves the pass/fail/timeout decisions that each DV bench currently makes in behavioural code into hardware, so the same verdict is visible on silicon via one status pin and in simulation via one net.

---
 rtl/stage_monitor_pkg.sv | 23 ++
 rtl/stage_monitor_chan.sv | 133 +++++++++++++
 rtl/stage_monitor.sv | 97 +++++++++
 tb/tb_stage_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_monitor_pkg.sv
// Shared types and default codes for the stage monitor and its per-channel
// sequencer.
package stage_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PASSED = 2'd2,
    ST_FAILED = 2'd3
  } chan_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ERROR   = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_SEQ     = 2'd3
  } fail_cause_t;

  localparam logic [7:0] DEF_START_CODE = 8'hFF;
  localparam logic [7:0] DEF_PASS_CODE  = 8'hFE;
  localparam int         CNT_W          = 4;

endpackage

// File: rtl/stage_monitor_chan.sv
// One monitored channel: input synchronizers, stability filter, stage
// sequencer FSM and per-stage watchdog.
module stage_monitor_chan
  import stage_monitor_pkg::*;
#(
  parameter int                 STAGE_W       = 8,
  parameter logic [STAGE_W-1:0] START_CODE    = DEF_START_CODE,
  parameter logic [STAGE_W-1:0] PASS_CODE     = DEF_PASS_CODE,
  parameter int                 STABLE_CYCLES = 4,
  parameter int                 TIMEOUT_W     = 24
) (
  input  logic                 i_clk,
  input  logic                 i_clear,
  input  logic [TIMEOUT_W-1:0] i_timeoutLimit,
  input  logic [STAGE_W-1:0]   i_stage,
  input  logic                 i_error,
  output logic [STAGE_W-1:0]   o_stage,
  output logic                 o_stageValid,
  output chan_state_t          o_state,
  output logic                 o_failNow,
  output fail_cause_t          o_failCause
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [STAGE_W-1:0]   r_stageMeta, r_stageSync, r_cand, r_expected, r_stageOut;
  logic                 r_errMeta, r_errSync, r_stageValid;
  logic [CNT_W-1:0]     r_cnt;
  logic [TIMEOUT_W-1:0] r_wdog;
  chan_state_t          r_state;

  logic                 w_accept, w_timeout;
  chan_state_t          w_stateNext;
  fail_cause_t          w_causeNext;
  logic [STAGE_W-1:0]   w_expNext;

  function automatic logic [STAGE_W-1:0] nextExpected(input logic [STAGE_W-1:0] cur);
    logic [STAGE_W-1:0] n;
    n = cur + STAGE_W'(1);
    for (int i = 0; i < 2; i++) begin
      if (n == START_CODE || n == PASS_CODE) n = n + STAGE_W'(1);
    end
    return n;
  endfunction

  // A saturated count out of clear treats the cleared code 0 as already
  // accepted, so leaving reset never produces a spurious stage pulse.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_stageMeta <= '0;
      r_stageSync <= '0;
      r_errMeta   <= 1'b0;
      r_errSync   <= 1'b0;
      r_cand      <= '0;
      r_cnt       <= STABLE;
    end else begin
      r_stageMeta <= i_stage;
      r_stageSync <= r_stageMeta;
      r_errMeta   <= i_error;
      r_errSync   <= r_errMeta;
      if (r_stageSync != r_cand) begin
        r_cand <= r_stageSync;
        r_cnt  <= CNT_W'(1);
      end else if (r_cnt < STABLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_accept = 1'b0;
    if (r_stageSync != r_cand) w_accept = (STABLE == CNT_W'(1));
    else if (r_cnt < STABLE)   w_accept = ((r_cnt + CNT_W'(1)) == STABLE);
  end

  assign w_timeout = (i_timeoutLimit != '0) && (r_wdog >= i_timeoutLimit);

  always_comb begin
    w_stateNext = r_state;
    w_causeNext = CAUSE_NONE;
    w_expNext   = r_expected;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && r_stageSync == START_CODE) begin
          w_stateNext = ST_RUN;
          w_expNext   = '0;
        end
      end
      ST_RUN: begin
        // Priority within one cycle: error, sequence, timeout, pass.
        if (r_errSync) begin
          w_stateNext = ST_FAILED;
          w_causeNext = CAUSE_ERROR;
        end else if (w_accept && r_stageSync != r_expected && r_stageSync != PASS_CODE) begin
          w_stateNext = ST_FAILED;
          w_causeNext = CAUSE_SEQ;
        end else if (w_timeout) begin
          w_stateNext = ST_FAILED;
          w_causeNext = CAUSE_TIMEOUT;
        end else if (w_accept && r_stageSync == PASS_CODE) begin
          w_stateNext = ST_PASSED;
        end else if (w_accept) begin
          w_expNext = nextExpected(r_expected);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state      <= ST_IDLE;
      r_expected   <= '0;
      r_wdog       <= '0;
      r_stageOut   <= '0;
      r_stageValid <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_expected   <= w_expNext;
      r_stageValid <= w_accept && (r_state != ST_FAILED);
      if (w_accept && r_state != ST_FAILED) r_stageOut <= r_stageSync;
      if (r_state != ST_RUN || w_accept) r_wdog <= '0;
      else if (r_wdog != '1)              r_wdog <= r_wdog + TIMEOUT_W'(1);
    end
  end

  assign o_stage      = r_stageOut;
  assign o_stageValid = r_stageValid;
  assign o_state      = r_state;
  assign o_failNow    = (r_state == ST_RUN) && (w_stateNext == ST_FAILED);
  assign o_failCause  = w_causeNext;

endmodule

// File: rtl/stage_monitor.sv
// Multi-channel stage monitor: one sequencer per channel plus the sticky
// pass/fail verdict with first-failure capture.
module stage_monitor
  import stage_monitor_pkg::*;
#(
  parameter int                 CHANNELS      = 1,
  parameter int                 STAGE_W       = 8,
  parameter logic [STAGE_W-1:0] START_CODE    = DEF_START_CODE,
  parameter logic [STAGE_W-1:0] PASS_CODE     = DEF_PASS_CODE,
  parameter int                 STABLE_CYCLES = 4,
  parameter int                 TIMEOUT_W     = 24
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  input  logic [CHANNELS*STAGE_W-1:0]   stage_i,
  input  logic [CHANNELS-1:0]           error_i,
  output logic [CHANNELS*STAGE_W-1:0]   stage_o,
  output logic [CHANNELS-1:0]           stage_valid_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic [1:0]                    fail_cause_o,
  output logic [2:0]                    fail_chan_o
);

  logic                w_clear;
  logic [CHANNELS-1:0] w_failNow, w_passed;
  chan_state_t         w_state [CHANNELS];
  fail_cause_t         w_cause [CHANNELS];
  logic [2:0]          w_firstChan;
  fail_cause_t         w_firstCause;

  logic                r_fail, r_pass;
  fail_cause_t         r_failCause;
  logic [2:0]          r_failChan;

  assign w_clear = wb_rst_i | ~enable;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    stage_monitor_chan #(
      .STAGE_W       (STAGE_W),
      .START_CODE    (START_CODE),
      .PASS_CODE     (PASS_CODE),
      .STABLE_CYCLES (STABLE_CYCLES),
      .TIMEOUT_W     (TIMEOUT_W)
    ) u_chan (
      .i_clk          (wb_clk_i),
      .i_clear        (w_clear),
      .i_timeoutLimit (timeout_limit),
      .i_stage        (stage_i[c*STAGE_W +: STAGE_W]),
      .i_error        (error_i[c]),
      .o_stage        (stage_o[c*STAGE_W +: STAGE_W]),
      .o_stageValid   (stage_valid_o[c]),
      .o_state        (w_state[c]),
      .o_failNow      (w_failNow[c]),
      .o_failCause    (w_cause[c])
    );
    assign w_passed[c] = (w_state[c] == ST_PASSED);
  end

  // Lowest-index channel wins when several fail on the same edge.
  always_comb begin
    w_firstChan  = '0;
    w_firstCause = CAUSE_NONE;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (w_failNow[c]) begin
        w_firstChan  = 3'(c);
        w_firstCause = w_cause[c];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_clear) begin
      r_fail      <= 1'b0;
      r_pass      <= 1'b0;
      r_failCause <= CAUSE_NONE;
      r_failChan  <= '0;
    end else begin
      if (!r_fail && |w_failNow) begin
        r_fail      <= 1'b1;
        r_failCause <= w_firstCause;
        r_failChan  <= w_firstChan;
      end
      if (!r_fail && !(|w_failNow) && &w_passed) r_pass <= 1'b1;
    end
  end

  assign fail_o       = r_fail;
  assign pass_o       = r_pass;
  assign done_o       = r_fail | r_pass;
  assign fail_cause_o = r_failCause;
  assign fail_chan_o  = r_failChan;

endmodule

// File: tb/tb_stage_monitor.sv
// Directed bench for stage_monitor: a single-channel and a three-channel
// instance driven from a vector table plus hand-written timing sequences.
module tb_stage_monitor;

  typedef struct {
    logic [7:0] stage;
    logic       err;
    int         hold;
    logic [7:0] expStage;
    int         expPulses;
    logic       expPass;
    logic       expFail;
    logic [1:0] expCause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [23:0] tlimit;

  logic [7:0]  stage1, stageO1;
  logic        err1, valid1, done1, pass1, fail1;
  logic [1:0]  cause1;
  logic [2:0]  chan1;

  logic [23:0] stage3, stageO3;
  logic [2:0]  err3, valid3;
  logic        done3, pass3, fail3;
  logic [1:0]  cause3;
  logic [2:0]  chan3;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [0:12];

  always #5 clk = ~clk;

  stage_monitor #(.CHANNELS(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .timeout_limit(tlimit),
    .stage_i(stage1), .error_i(err1), .stage_o(stageO1), .stage_valid_o(valid1),
    .done_o(done1), .pass_o(pass1), .fail_o(fail1),
    .fail_cause_o(cause1), .fail_chan_o(chan1)
  );

  stage_monitor #(.CHANNELS(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .timeout_limit(tlimit),
    .stage_i(stage3), .error_i(err3), .stage_o(stageO3), .stage_valid_o(valid3),
    .done_o(done3), .pass_o(pass3), .fail_o(fail3),
    .fail_cause_o(cause3), .fail_chan_o(chan3)
  );

  function automatic vec_t mkVec(input logic [7:0] stage, input logic err, input int hold,
                                 input logic [7:0] expStage, input int expPulses,
                                 input logic expPass, input logic expFail, input logic [1:0] expCause);
    vec_t v;
    v.stage = stage; v.err = err; v.hold = hold; v.expStage = expStage;
    v.expPulses = expPulses; v.expPass = expPass; v.expFail = expFail; v.expCause = expCause;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive channel-0 inputs for hold cycles and count stage_valid_o pulses seen.
  task automatic applyStimulus(input logic [7:0] stage, input logic err, input int hold, output int pulses);
    stage1 = stage;
    err1   = err;
    pulses = 0;
    repeat (hold) begin
      @(negedge clk);
      if (valid1) pulses++;
    end
  endtask

  task automatic runVectors(input int first, input int last);
    int p;
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].stage, vecs[i].err, vecs[i].hold, p);
      checkOutput($sformatf("v%0d stage_o", i), 32'(stageO1), 32'(vecs[i].expStage));
      checkOutput($sformatf("v%0d pulses", i), 32'(p), 32'(vecs[i].expPulses));
      checkOutput($sformatf("v%0d pass_o", i), 32'(pass1), 32'(vecs[i].expPass));
      checkOutput($sformatf("v%0d fail_o", i), 32'(fail1), 32'(vecs[i].expFail));
      checkOutput($sformatf("v%0d done_o", i), 32'(done1), 32'(vecs[i].expPass | vecs[i].expFail));
      checkOutput($sformatf("v%0d cause", i), 32'(cause1), 32'(vecs[i].expCause));
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " stage_o"}, 32'(stageO1), 32'h0);
    checkOutput({tag, " valid"}, 32'(valid1), 32'h0);
    checkOutput({tag, " done"}, 32'({done1, pass1, fail1}), 32'h0);
    checkOutput({tag, " cause/chan"}, 32'({cause1, chan1}), 32'h0);
    checkOutput({tag, " dut3 stage_o"}, 32'(stageO3), 32'h0);
    checkOutput({tag, " dut3 flags"}, 32'({valid3, done3, pass3, fail3, cause3, chan3}), 32'h0);
  endtask

  task automatic clearByEnable(input string tag);
    stage1 = 8'h00; err1 = 1'b0; stage3 = 24'h0; err3 = 3'b000;
    enable = 1'b0;
    tick(1);
    checkCleared(tag);
    enable = 1'b1;
  endtask

  initial begin
    int p;
    vecs[0]  = mkVec(8'h00, 1'b1, 10, 8'h00, 0, 1'b0, 1'b0, 2'd0);
    vecs[1]  = mkVec(8'hFF, 1'b0, 20, 8'hFF, 1, 1'b0, 1'b0, 2'd0);
    vecs[2]  = mkVec(8'h00, 1'b0, 20, 8'h00, 1, 1'b0, 1'b0, 2'd0);
    vecs[3]  = mkVec(8'h01, 1'b0, 20, 8'h01, 1, 1'b0, 1'b0, 2'd0);
    vecs[4]  = mkVec(8'h02, 1'b0, 20, 8'h02, 1, 1'b0, 1'b0, 2'd0);
    vecs[5]  = mkVec(8'hFE, 1'b0, 20, 8'hFE, 1, 1'b1, 1'b0, 2'd0);
    vecs[6]  = mkVec(8'hFF, 1'b0, 20, 8'hFF, 1, 1'b0, 1'b0, 2'd0);
    vecs[7]  = mkVec(8'h00, 1'b0, 20, 8'h00, 1, 1'b0, 1'b0, 2'd0);
    vecs[8]  = mkVec(8'h02, 1'b0, 20, 8'h02, 1, 1'b0, 1'b1, 2'd3);
    vecs[9]  = mkVec(8'hFF, 1'b0, 20, 8'hFF, 1, 1'b0, 1'b0, 2'd0);
    vecs[10] = mkVec(8'h00, 1'b0, 20, 8'h00, 1, 1'b0, 1'b0, 2'd0);
    vecs[11] = mkVec(8'h05, 1'b0,  2, 8'h00, 0, 1'b0, 1'b0, 2'd0);
    vecs[12] = mkVec(8'h01, 1'b0, 20, 8'h01, 1, 1'b0, 1'b0, 2'd0);

    rst = 1'b1; enable = 1'b1; tlimit = 24'd0;
    stage1 = 8'h00; err1 = 1'b0; stage3 = 24'h0; err3 = 3'b000;
    tick(3);
    checkCleared("reset");
    rst = 1'b0;

    // Full pass sequence, error in IDLE ignored.
    runVectors(0, 5);
    clearByEnable("enable-after-pass");

    // Skipped stage is a sequence violation.
    runVectors(6, 8);
    checkOutput("seq fail_chan", 32'(chan1), 32'h0);
    clearByEnable("enable-after-seq");

    // Short glitch rejected, then error in RUN fails three cycles later.
    runVectors(9, 12);
    err1 = 1'b1;
    tick(2);
    checkOutput("err fail_o early", 32'(fail1), 32'h0);
    tick(1);
    checkOutput("err fail_o", 32'(fail1), 32'h1);
    checkOutput("err cause", 32'(cause1), 32'h1);
    checkOutput("err chan", 32'(chan1), 32'h0);
    err1 = 1'b0;
    clearByEnable("enable-after-err");

    // Accept latency and watchdog expiry.
    tlimit = 24'd50;
    stage1 = 8'hFF;
    tick(5);
    checkOutput("accept early", 32'(valid1), 32'h0);
    tick(1);
    checkOutput("accept latency", 32'(valid1), 32'h1);
    checkOutput("accept stage_o", 32'(stageO1), 32'hFF);
    tick(50);
    checkOutput("wdog fail early", 32'(fail1), 32'h0);
    tick(1);
    checkOutput("wdog fail_o", 32'(fail1), 32'h1);
    checkOutput("wdog cause", 32'(cause1), 32'h2);
    clearByEnable("enable-after-wdog");

    // Watchdog disabled.
    tlimit = 24'd0;
    stage1 = 8'hFF;
    tick(10000);
    checkOutput("wdog off fail_o", 32'(fail1), 32'h0);
    checkOutput("wdog off stage_o", 32'(stageO1), 32'hFF);
    clearByEnable("enable-after-wdog-off");

    // Three channels pass together; pass_o one cycle after the PASS pulse.
    stage3 = {3{8'hFF}};
    tick(20);
    checkOutput("3ch armed stage_o", 32'(stageO3), 32'hFFFFFF);
    stage3 = {3{8'h00}};
    tick(20);
    stage3 = {3{8'hFE}};
    tick(6);
    checkOutput("3ch pass pulse", 32'(valid3), 32'h7);
    checkOutput("3ch pass early", 32'(pass3), 32'h0);
    tick(1);
    checkOutput("3ch pass_o", 32'({done3, pass3, fail3}), 32'h6);
    clearByEnable("enable-after-3ch-pass");

    // ch1 and ch2 error on the same cycle; ch0 later passes.
    stage3 = {3{8'hFF}};
    tick(20);
    err3 = 3'b110;
    tick(3);
    checkOutput("3ch fail_o", 32'(fail3), 32'h1);
    checkOutput("3ch fail_chan", 32'(chan3), 32'h1);
    checkOutput("3ch fail_cause", 32'(cause3), 32'h1);
    err3 = 3'b000;
    stage3 = {8'hFF, 8'hFF, 8'h00};
    tick(20);
    stage3 = {8'hFF, 8'hFF, 8'hFE};
    tick(20);
    checkOutput("3ch ch0 stage_o", 32'(stageO3[7:0]), 32'hFE);
    checkOutput("3ch verdict kept", 32'({done3, pass3, fail3, cause3, chan3}), 32'({1'b1, 1'b0, 1'b1, 2'd1, 3'd1}));
    clearByEnable("enable-after-3ch-fail");

    // Reset mid-RUN with a new code in flight through the synchronizer.
    stage1 = 8'hFF;
    tick(20);
    checkOutput("mid-run armed", 32'(stageO1), 32'hFF);
    stage1 = 8'h01;
    tick(2);
    rst = 1'b1;
    stage1 = 8'h00;
    tick(1);
    checkCleared("mid-run reset");
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 20, p);
    checkOutput("post-reset pulses", 32'(p), 32'h0);
    applyStimulus(8'hFF, 1'b0, 20, p);
    checkOutput("restart pulses", 32'(p), 32'h1);
    checkOutput("restart stage_o", 32'(stageO1), 32'hFF);
    applyStimulus(8'h00, 1'b0, 20, p);
    checkOutput("restart seq", 32'({p[1:0], fail1}), 32'({2'd1, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
